pb_event_queue: RTL and testbench
=================================

Name: pb_event_queue

Overview:
- Sits directly downstream of the push-button debouncer. It consumes that stage's one-cycle, per-button edge pulses.
- Each pulse is converted into a 2-bit button code and buffered in a small FIFO.
- The top-level control FSM (e.g. decompressor start/step control) reads the codes through a valid/ready handshake.
- Simultaneous presses are serialized lowest-index-first. Lost presses are reported through a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO depth in entries; power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived; not to be overridden).

Ports:
- Clock_50  input  1  system clock, 50 MHz, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- PB_pushed  input  4  one-cycle press pulses from the debouncer; bit i = button i.
- Event_valid  output  1  high when the FIFO holds at least one event.
- Event_code  output  2  button index at the FIFO head; valid only while Event_valid=1.
- Event_ready  input  1  consumer accepts the head entry when Event_valid & Event_ready.
- Event_count  output  AW+1  number of entries currently in the FIFO (0..DEPTH).
- Overflow  output  1  sticky flag: at least one press was lost.
- Clear_overflow  input  1  synchronous clear of Overflow.

Behaviour:
- Reset (asynchronous, immediate) sets all of the following to zero, with no residual events after release:
  - pending[3:0], rd_ptr, wr_ptr, count, Overflow.
  - Therefore Event_valid=0, Event_count=0, Event_code=0.
- Stage 1, pending capture, at each rising edge:
  - pending_next = (pending & ~grant) | PB_pushed.
  - grant is the one-hot bit being pushed this cycle (0 if no push).
- Push rule:
  - push = (pending != 0) & (count < DEPTH | pop).
  - grant = lowest set bit of pending.
  - The written code is the index of grant; wr_ptr increments and wraps modulo DEPTH.
- Pop rule:
  - pop = Event_valid & Event_ready.
  - rd_ptr increments and wraps modulo DEPTH.
  - Event_ready while empty is ignored.
- Count:
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Push is permitted when full only if pop occurs in the same cycle.
- Outputs:
  - Event_code = mem[rd_ptr], combinational read of the register array.
  - Event_valid = (count != 0).
  - Event_count = count.
- Latency: a pulse on PB_pushed[i] sampled at edge N sets pending[i] at N, and the entry is written at edge N+1. With an empty FIFO and no other pending bits, Event_valid rises after edge N+1 (2 cycles).
- Coalescing/loss:
  - If PB_pushed[i]=1 while pending[i]=1 and bit i is not granted that cycle, the press is lost and Overflow <= 1.
  - If bit i is granted in the same cycle a new pulse on i arrives, pending[i] stays 1 as a new event. No overflow.
- Full FIFO: pending bits wait indefinitely. New pulses on bits not yet pending are captured normally.
- Overflow:
  - Set when a press is lost; cleared by Clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- Ordering:
  - Events from different cycles are delivered in arrival order.
  - Events from the same cycle are delivered in ascending button index.
  - Exception: an event already pending (waiting behind a full FIFO) is delivered in index order relative to newer pending bits.
- No combinational path from PB_pushed to any output. Event_ready affects only state, not outputs, in the same cycle.

Test Plan:
- Single press: reset, PB_pushed=4'b0100 for 1 cycle at edge N -> Event_valid=1, Event_code=2, Event_count=1 after edge N+1. Event_ready=1 for 1 cycle -> Event_valid=0, count=0.
- Simultaneous presses: PB_pushed=4'b1011 for 1 cycle, Event_ready=0 -> after 3 further edges count=3, and pops yield codes 0,1,3 in order. Overflow=0.
- Full and backpressure (DEPTH=4): press buttons 0,1,2,3,0 on separate cycles, no pops -> count=4, second button-0 press held pending. One pop -> code 0 delivered; next edge count=4 with code 0 as the last entry. Overflow=0.
- Loss: FIFO full, pending[1]=1, pulse PB_pushed[1] again -> Overflow=1. Clear_overflow=1 with no new loss -> Overflow=0. Clear coincident with a new loss -> Overflow stays 1.
- Push+pop at full: count=4, pending[2]=1, Event_ready=1 -> that edge pops head and pushes code 2; count stays 4. Pointers wrap correctly across 3 full cycles of DEPTH (order checked against a reference model).
- Reset mid-operation: count=3, pending=4'b0110, assert Reset asynchronously between edges -> Event_valid, Event_count, Overflow drop to 0 immediately. After release, no stale events appear within 10 cycles.

Source files
------------

// File: rtl/pb_event_queue.sv
// Push-button event queue: turns debounced per-button press pulses into 2-bit
// button codes and buffers them in a small FIFO read through valid/ready.
module pb_event_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clock_50,
  input  logic          Reset,
  input  logic [3:0]    PB_pushed,
  output logic          Event_valid,
  output logic [1:0]    Event_code,
  input  logic          Event_ready,
  output logic [AW:0]   Event_count,
  output logic          Overflow,
  input  logic          Clear_overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [3:0]    pending;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow_q;

  logic          push;
  logic          pop;
  logic [3:0]    grant;
  logic [1:0]    grant_idx;
  logic          lost;

  assign pop  = (count != '0) & Event_ready;
  assign push = (pending != 4'b0) & ((count != FULL) | pop);

  // Lowest pending button wins; grant is zero when nothing is pushed.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) grant_idx = 2'(i);
    end
  end

  assign grant = push ? (4'b0001 << grant_idx) : 4'b0000;
  // A pulse on a bit still waiting (and not being drained now) cannot be stored.
  assign lost  = |(PB_pushed & pending & ~grant);

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      pending    <= 4'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
    end else begin
      pending <= (pending & ~grant) | PB_pushed;
      if (push) begin
        mem[wr_ptr] <= grant_idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (lost)                overflow_q <= 1'b1;
      else if (Clear_overflow) overflow_q <= 1'b0;
    end
  end

  assign Event_valid = (count != '0);
  assign Event_code  = mem[rd_ptr];
  assign Event_count = count;
  assign Overflow    = overflow_q;

endmodule

// File: tb/tb_pb_event_queue.sv
// Self-checking bench for pb_event_queue: directed scenarios plus random
// traffic, scored against a queue-based reference model.
module tb_pb_event_queue;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clock;
  logic          reset;
  logic [3:0]    pbPushed;
  logic          eventValid;
  logic [1:0]    eventCode;
  logic          eventReady;
  logic [AW:0]   eventCount;
  logic          overflow;
  logic          clearOverflow;

  pb_event_queue #(.DEPTH(DEPTH)) dut (
    .Clock_50      (clock),
    .Reset         (reset),
    .PB_pushed     (pbPushed),
    .Event_valid   (eventValid),
    .Event_code    (eventCode),
    .Event_ready   (eventReady),
    .Event_count   (eventCount),
    .Overflow      (overflow),
    .Clear_overflow(clearOverflow)
  );

  typedef struct {
    int count;
    bit ovf;
  } status_t;

  int      compared = 0;
  int      mismatched = 0;
  bit      inReset = 1;
  status_t statusQ[$];
  int      codeQ[$];

  // Reference model: a set of waiting buttons, an event count and a sticky flag.
  bit [3:0] modelPending = 4'b0;
  int       modelCount = 0;
  bit       modelOvf = 0;

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    modelPending = 4'b0;
    modelCount   = 0;
    modelOvf     = 0;
    statusQ.delete();
    codeQ.delete();
  endtask

  // Called at posedge+1: records the state the DUT must show this cycle, drives
  // the inputs for this cycle and advances the model by one edge.
  task automatic applyStimulus(input bit [3:0] pb, input bit rdy, input bit clr);
    status_t st;
    bit      lost;
    st.count = modelCount;
    st.ovf   = modelOvf;
    statusQ.push_back(st);
    pbPushed      = pb;
    eventReady    = rdy;
    clearOverflow = clr;
    if (rdy && modelCount > 0) modelCount--;
    if (modelPending != 0 && modelCount < DEPTH) begin
      for (int i = 0; i < 4; i++) begin
        if (modelPending[i]) begin
          codeQ.push_back(i);
          modelPending[i] = 1'b0;
          modelCount++;
          break;
        end
      end
    end
    lost = |(pb & modelPending);
    modelPending = modelPending | pb;
    if (lost) modelOvf = 1;
    else if (clr) modelOvf = 0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(4'b0, rdy, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic midReset();
    #3;
    inReset = 1;
    reset   = 1'b1;
    pbPushed = 4'b0; eventReady = 1'b0; clearOverflow = 1'b0;
    #1;
    checkOutput("async_reset_valid", int'(eventValid), 0);
    checkOutput("async_reset_count", int'(eventCount), 0);
    checkOutput("async_reset_overflow", int'(overflow), 0);
    checkOutput("async_reset_code", int'(eventCode), 0);
    resetModel();
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    inReset = 0;
  endtask

  // Monitor: compares the visible state each cycle and the code on every handshake.
  always @(negedge clock) begin
    status_t st;
    if (!inReset && statusQ.size() > 0) begin
      st = statusQ.pop_front();
      checkOutput("event_count", int'(eventCount), st.count);
      checkOutput("event_valid", int'(eventValid), int'(st.count != 0));
      checkOutput("overflow", int'(overflow), int'(st.ovf));
      if (eventValid && eventReady) begin
        if (codeQ.size() == 0) checkOutput("unexpected_event", int'(eventCode), -1);
        else checkOutput("event_code", int'(eventCode), codeQ.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    pbPushed = 4'b0; eventReady = 1'b0; clearOverflow = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_valid", int'(eventValid), 0);
    checkOutput("reset_count", int'(eventCount), 0);
    checkOutput("reset_code", int'(eventCode), 0);
    reset = 1'b0;
    inReset = 0;

    // Single press: visible two edges after the pulse, then consumed.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Simultaneous presses serialize lowest index first.
    applyStimulus(4'b1011, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(4, 1'b1);

    // Fill, hold a press pending, lose presses, exercise clear versus set.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0001, 1'b0, 1'b1);
    idle(2, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    idle(2, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Reset with events both queued and pending, then confirm nothing stale appears.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b0, 1'b0);
    midReset();
    idle(10, 1'b1);

    // Random traffic in phases of light and heavy backpressure.
    for (int phase = 0; phase < 8; phase++) begin
      for (int c = 0; c < 250; c++) begin
        bit [3:0] pb;
        for (int b = 0; b < 4; b++) pb[b] = ($urandom_range(0, 5) == 0);
        applyStimulus(pb,
                      ($urandom_range(0, 9) < ((phase % 2 == 0) ? 2 : 8)),
                      ($urandom_range(0, 9) == 0));
      end
      if (phase == 5) midReset();
    end
    idle(20, 1'b1);
    checkOutput("drained_codes", codeQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
